// File: rtl/pagerank_pkg.sv
// rtl/pagerank_pkg.sv - shared types and constants for the PageRank NoC arbiter
package pagerank_pkg;

    localparam int NUM_ANTS_DEF = 4;
    localparam int N_DEF        = 16;
    localparam int WIDTH_DEF    = 32;

    // page_id width for M = 64 pages
    localparam int PAGE_W = 6;
    // request slice: {page_id, valid}
    localparam int REQ_W  = PAGE_W + 1;
    // response slice: {data, page_id, valid}
    localparam int RESP_W = WIDTH_DEF + REQ_W;

    localparam int RESP_VALID_BIT = 0;
    localparam int RESP_PAGE_LSB  = 1;
    localparam int RESP_DATA_LSB  = 1 + PAGE_W;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] GRANT_COUNT_RST = '0;
    localparam logic [CNT_W-1:0] GRANT_COUNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        RESPOND = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker
// Ports:
//   req       in  NUM_ANTS  request valid per ant
//   rr_ptr    in  IDX_W     first ant considered
//   grant_oh  out NUM_ANTS  one-hot grant
//   grant_idx out IDX_W     index of the granted ant
//   any_valid out 1         at least one request present
module rr_arbiter #(
    parameter int NUM_ANTS = 4,
    parameter int IDX_W    = 2
) (
    input  logic [NUM_ANTS-1:0] req,
    input  logic [IDX_W-1:0]    rr_ptr,
    output logic [NUM_ANTS-1:0] grant_oh,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                any_valid
);

    always_comb begin
        int cand;
        grant_oh  = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        cand      = 0;
        // Walk ants starting at rr_ptr, wrapping; first valid wins.
        for (int i = 0; i < NUM_ANTS; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_ANTS) begin
                cand = cand - NUM_ANTS;
            end
            if (!any_valid && req[cand]) begin
                any_valid      = 1'b1;
                grant_oh[cand] = 1'b1;
                grant_idx      = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/noc_page_arbiter.sv
// rtl/noc_page_arbiter.sv - single-transaction NoC switch for PageRank page-value lookups
// Optional macro: NOC_ARB_STATS_EN builds per-ant saturating grant counters.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   request      per ant {page_id, valid}
//   reply        per ant value for its current query
//   query        per ant page_id to look up (registered)
//   response     per ant {data, page_id, valid} (registered, valid one cycle)
//   busy         high while a transaction is in flight
//   grant_count  per ant completed-transaction counters
module noc_page_arbiter
    import pagerank_pkg::*;
#(
    parameter int NUM_ANTS = NUM_ANTS_DEF,
    parameter int N        = N_DEF,
    parameter int WIDTH    = WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_ANTS*REQ_W-1:0]         request,
    input  logic [NUM_ANTS*WIDTH-1:0]         reply,
    output logic [NUM_ANTS*PAGE_W-1:0]        query,
    output logic [NUM_ANTS*(WIDTH+REQ_W)-1:0] response,
    output logic                              busy,
    output logic [NUM_ANTS*CNT_W-1:0]         grant_count
);

    localparam int RW    = WIDTH + REQ_W;
    localparam int IDX_W = (NUM_ANTS > 1) ? $clog2(NUM_ANTS) : 1;

    arb_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]           grant_idx_q, grant_idx_d;
    logic [PAGE_W-1:0]          page_q, page_d;
    logic [IDX_W-1:0]           owner_q, owner_d;
    logic [WIDTH-1:0]           data_q, data_d;
    logic [NUM_ANTS*PAGE_W-1:0] query_q, query_d;
    logic [NUM_ANTS*RW-1:0]     response_q, response_d;

    logic [NUM_ANTS-1:0] req_valid;
    logic [NUM_ANTS-1:0] arb_oh;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [PAGE_W-1:0]   sel_page;
    logic [IDX_W-1:0]    sel_owner;

    always_comb begin
        req_valid = '0;
        sel_page  = '0;
        for (int a = 0; a < NUM_ANTS; a++) begin
            req_valid[a] = request[a*REQ_W];
            // AND-OR mux on the one-hot grant
            if (arb_oh[a]) begin
                sel_page = sel_page | request[a*REQ_W+1 +: PAGE_W];
            end
        end
        // With M = NUM_ANTS*N the quotient always fits in IDX_W bits.
        sel_owner = IDX_W'(int'(sel_page) / N);
    end

    rr_arbiter #(
        .NUM_ANTS (NUM_ANTS),
        .IDX_W    (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .any_valid (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        page_d      = page_q;
        owner_d     = owner_q;
        data_d      = data_q;
        query_d     = query_q;
        response_d  = response_q;
        // Response valids are single-cycle pulses; data/page fields hold.
        for (int a = 0; a < NUM_ANTS; a++) begin
            response_d[a*RW+RESP_VALID_BIT] = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_idx_d = arb_idx;
                    page_d      = sel_page;
                    owner_d     = sel_owner;
                    query_d[int'(sel_owner)*PAGE_W +: PAGE_W] = sel_page;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                data_d  = reply[int'(owner_q)*WIDTH +: WIDTH];
                state_d = RESPOND;
            end
            RESPOND: begin
                response_d[int'(grant_idx_q)*RW +: RW] = {data_q, page_q, 1'b1};
                rr_ptr_d = (grant_idx_q == IDX_W'(NUM_ANTS - 1)) ? '0 : grant_idx_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            page_q      <= '0;
            owner_q     <= '0;
            data_q      <= '0;
            query_q     <= '0;
            response_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            page_q      <= page_d;
            owner_q     <= owner_d;
            data_q      <= data_d;
            query_q     <= query_d;
            response_q  <= response_d;
        end
    end

    assign query    = query_q;
    assign response = response_q;
    assign busy     = (state_q != IDLE);

`ifdef NOC_ARB_STATS_EN
    logic [NUM_ANTS*CNT_W-1:0] grant_count_q, grant_count_d;

    always_comb begin
        grant_count_d = grant_count_q;
        for (int a = 0; a < NUM_ANTS; a++) begin
            if (state_q == RESPOND && grant_idx_q == IDX_W'(a)
                && grant_count_q[a*CNT_W +: CNT_W] != GRANT_COUNT_MAX) begin
                grant_count_d[a*CNT_W +: CNT_W] = grant_count_q[a*CNT_W +: CNT_W] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count_q <= {NUM_ANTS{GRANT_COUNT_RST}};
        end else begin
            grant_count_q <= grant_count_d;
        end
    end

    assign grant_count = grant_count_q;
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_noc_page_arbiter.sv
// tb/tb_noc_page_arbiter.sv - self-checking bench for noc_page_arbiter
module tb_noc_page_arbiter;
    import pagerank_pkg::*;

    localparam int NA = 4;
    localparam int NP = 16;
    localparam int W  = 32;
    localparam int RW = W + 7;

    logic              clk = 1'b0;
    logic              reset;
    logic [NA*7-1:0]   request;
    logic [NA*W-1:0]   reply;
    logic [NA*6-1:0]   query;
    logic [NA*RW-1:0]  response;
    logic              busy;
    logic [NA*16-1:0]  grant_count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit fixed_reply = 1'b0;

    // reference model: pending requests and round-robin pointer
    int m_ptr;
    bit m_valid[NA];
    int exp_count[NA];

    always #5 clk = ~clk;

    noc_page_arbiter #(.NUM_ANTS(NA), .N(NP), .WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .reply       (reply),
        .query       (query),
        .response    (response),
        .busy        (busy),
        .grant_count (grant_count)
    );

    function automatic logic [31:0] ant_value(int a, int p);
        return (32'(a + 1) * 32'h0101_0001) ^ (32'(p) << 8) ^ 32'hC0DE_0000;
    endfunction

    // ants answer combinationally from their query port
    always_comb begin
        reply = '0;
        for (int a = 0; a < NA; a++) begin
            reply[a*W +: W] = ant_value(a, int'(query[a*6 +: 6]));
            if (fixed_reply && a == 2) reply[a*W +: W] = 32'h1234_5678;
        end
    end

    function automatic logic [RW-1:0] exp_word(int p);
        return {ant_value(p / NP, p), 6'(p), 1'b1};
    endfunction

    function automatic int model_pick();
        for (int i = 0; i < NA; i++) begin
            if (m_valid[(m_ptr + i) % NA]) return (m_ptr + i) % NA;
        end
        return -1;
    endfunction

    function automatic int stats_exp(int a);
`ifdef NOC_ARB_STATS_EN
        return exp_count[a];
`else
        return 0 * a;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(int a, bit v, int p);
        request[a*7 +: 7] = {6'(p), v};
        m_valid[a] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        request = '0;
        tick();
        tick();
        reset = 1'b0;
        m_ptr = 0;
        for (int a = 0; a < NA; a++) begin
            m_valid[a] = 1'b0;
            exp_count[a] = 0;
        end
    endtask

    // advance until a response valid appears (bounded); ant=-1 on timeout, -2 if several
    task automatic wait_resp(output int ant, output int cyc, output logic [RW-1:0] word,
                             output logic [7:0] busym);
        int nv;
        ant = -1; cyc = 0; word = '0; busym = '0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            busym[c-1] = busy;
            nv = 0;
            for (int a = 0; a < NA; a++) begin
                if (response[a*RW]) begin
                    nv++;
                    ant = a;
                    word = response[a*RW +: RW];
                end
            end
            if (nv > 1) ant = -2;
            if (nv != 0) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        request = '0;
        tick();
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if (query !== '0) $display("FAIL reset_query got %h want 0", query); else pass_cnt++;
        total_cnt++; if (response !== '0) $display("FAIL reset_response got %h want 0", response); else pass_cnt++;
        total_cnt++; if (grant_count !== '0) $display("FAIL reset_grant_count got %h want 0", grant_count); else pass_cnt++;
        reset = 1'b0;
        m_ptr = 0;
        for (int a = 0; a < NA; a++) begin m_valid[a] = 1'b0; exp_count[a] = 0; end
        repeat (3) tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy got %0b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_single();
        logic [RW-1:0] want;
        fixed_reply = 1'b1;
        set_req(1, 1'b1, 40);
        tick();
        total_cnt++; if (query[2*6 +: 6] !== 6'd40) $display("FAIL single_query got %0d want 40", query[2*6 +: 6]); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy got %0b want 1", busy); else pass_cnt++;
        tick();
        total_cnt++; if (response[1*RW] !== 1'b0) $display("FAIL single_early got %0b want 0", response[1*RW]); else pass_cnt++;
        tick();
        want = {32'h1234_5678, 6'd40, 1'b1};
        total_cnt++; if (response[1*RW +: RW] !== want) $display("FAIL single_resp got %h want %h", response[1*RW +: RW], want); else pass_cnt++;
        set_req(1, 1'b0, 0);
        exp_count[1]++;
        m_ptr = 2;
        tick();
        fixed_reply = 1'b0;
        total_cnt++; if (response[1*RW] !== 1'b0) $display("FAIL single_pulse got %0b want 0", response[1*RW]); else pass_cnt++;
    endtask

    task automatic test_all_four();
        int ant, cyc, g, pg[NA];
        logic [RW-1:0] word;
        logic [7:0] bm;
        do_reset();
        for (int a = 0; a < NA; a++) begin
            pg[a] = $urandom_range(0, 63);
            set_req(a, 1'b1, pg[a]);
        end
        for (int k = 0; k < NA; k++) begin
            g = model_pick();
            wait_resp(ant, cyc, word, bm);
            total_cnt++; if (ant !== g) $display("FAIL all4_grant got %0d want %0d", ant, g); else pass_cnt++;
            total_cnt++; if (cyc !== 3) $display("FAIL all4_latency got %0d want 3", cyc); else pass_cnt++;
            total_cnt++; if (bm !== 8'b0000_0011) $display("FAIL all4_busy got %b want 00000011", bm); else pass_cnt++;
            if (g >= 0) begin
                total_cnt++; if (word !== exp_word(pg[g])) $display("FAIL all4_word got %h want %h", word, exp_word(pg[g])); else pass_cnt++;
                set_req(g, 1'b0, 0);
                exp_count[g]++;
                m_ptr = (g + 1) % NA;
            end
        end
    endtask

    task automatic test_wrap();
        int ant, cyc, g, pg[NA];
        logic [RW-1:0] word;
        logic [7:0] bm;
        pg[0] = $urandom_range(0, 63);
        pg[3] = $urandom_range(0, 63);
        set_req(0, 1'b1, pg[0]);
        set_req(3, 1'b1, pg[3]);
        for (int k = 0; k < 2; k++) begin
            g = model_pick();
            wait_resp(ant, cyc, word, bm);
            total_cnt++; if (ant !== g) $display("FAIL wrap_grant got %0d want %0d", ant, g); else pass_cnt++;
            if (g >= 0) begin
                total_cnt++; if (word !== exp_word(pg[g])) $display("FAIL wrap_word got %h want %h", word, exp_word(pg[g])); else pass_cnt++;
                set_req(g, 1'b0, 0);
                exp_count[g]++;
                m_ptr = (g + 1) % NA;
            end
        end
    endtask

    task automatic test_withdraw();
        int ant, cyc, p;
        logic [RW-1:0] word;
        logic [7:0] bm;
        p = $urandom_range(0, 63);
        set_req(2, 1'b1, p);
        tick();
        set_req(2, 1'b0, 0);
        wait_resp(ant, cyc, word, bm);
        total_cnt++; if (ant !== 2) $display("FAIL withdraw_grant got %0d want 2", ant); else pass_cnt++;
        total_cnt++; if (word !== exp_word(p)) $display("FAIL withdraw_word got %h want %h", word, exp_word(p)); else pass_cnt++;
        exp_count[2]++;
        m_ptr = 3;
        wait_resp(ant, cyc, word, bm);
        total_cnt++; if (ant !== -1) $display("FAIL withdraw_extra got %0d want -1", ant); else pass_cnt++;
        total_cnt++; if (bm !== 8'h00) $display("FAIL withdraw_idle_busy got %b want 00000000", bm); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int ant, cyc;
        logic [RW-1:0] word;
        logic [7:0] bm;
        set_req(0, 1'b1, $urandom_range(0, 63));
        tick();
        reset = 1'b1;
        request = '0;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if (response !== '0) $display("FAIL rstmid_response got %h want 0", response); else pass_cnt++;
        total_cnt++; if (query !== '0) $display("FAIL rstmid_query got %h want 0", query); else pass_cnt++;
        reset = 1'b0;
        m_ptr = 0;
        for (int a = 0; a < NA; a++) begin m_valid[a] = 1'b0; exp_count[a] = 0; end
        wait_resp(ant, cyc, word, bm);
        total_cnt++; if (ant !== -1) $display("FAIL rstmid_pulse got %0d want -1", ant); else pass_cnt++;
    endtask

    task automatic test_stats();
        int ant, cyc, p;
        logic [RW-1:0] word;
        logic [7:0] bm;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            p = $urandom_range(0, 63);
            set_req(1, 1'b1, p);
            wait_resp(ant, cyc, word, bm);
            total_cnt++; if (ant !== 1) $display("FAIL stats_grant got %0d want 1", ant); else pass_cnt++;
            set_req(1, 1'b0, 0);
            exp_count[1]++;
            m_ptr = 2;
        end
        for (int a = 0; a < NA; a++) begin
            total_cnt++;
            if (int'(grant_count[a*16 +: 16]) !== stats_exp(a))
                $display("FAIL stats_count ant %0d got %0d want %0d", a, grant_count[a*16 +: 16], stats_exp(a));
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int ant, cyc, g, pg[NA];
        logic [RW-1:0] word;
        logic [7:0] bm;
        for (int a = 0; a < NA; a++) pg[a] = 0;
        for (int it = 0; it < 40; it++) begin
            for (int a = 0; a < NA; a++) begin
                if (!m_valid[a] && $urandom_range(0, 1) == 1) begin
                    pg[a] = $urandom_range(0, 63);
                    set_req(a, 1'b1, pg[a]);
                end
            end
            g = model_pick();
            wait_resp(ant, cyc, word, bm);
            total_cnt++; if (ant !== g) $display("FAIL rand_grant it %0d got %0d want %0d", it, ant, g); else pass_cnt++;
            if (g >= 0) begin
                total_cnt++; if (cyc !== 3) $display("FAIL rand_latency it %0d got %0d want 3", it, cyc); else pass_cnt++;
                total_cnt++; if (word !== exp_word(pg[g])) $display("FAIL rand_word it %0d got %h want %h", it, word, exp_word(pg[g])); else pass_cnt++;
                set_req(g, 1'b0, 0);
                exp_count[g]++;
                m_ptr = (g + 1) % NA;
            end
        end
        for (int a = 0; a < NA; a++) begin
            total_cnt++;
            if (int'(grant_count[a*16 +: 16]) !== stats_exp(a))
                $display("FAIL rand_count ant %0d got %0d want %0d", a, grant_count[a*16 +: 16], stats_exp(a));
            else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1;
        request = '0;
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_withdraw();
        test_reset_mid();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
